// File: rtl/alu_seq.sv
// Nibble-serial ALU sequencer: accepts one 8-bit ALU operation and steps the
// 4-bit ALU through load-A, low-nibble and high-nibble cycles, then reports result and flags.
module alu_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic       req_cf,
    output logic [7:0] alu_op,
    output logic       alu_la,
    output logic       alu_lb,
    output logic [1:0] alu_fn,
    output logic       alu_neg,
    output logic       alu_ci,
    output logic       alu_lo,
    output logic       alu_hi,
    output logic       alu_res_oe,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_zero,
    output logic       rsp_valid,
    output logic       rsp_wr,
    output logic [7:0] rsp_result,
    output logic [3:0] rsp_flags
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LDA  = 3'd1;
    localparam logic [2:0] ST_LO   = 3'd2;
    localparam logic [2:0] ST_HI   = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_CP  = 3'd7;

    localparam logic [1:0] FN_ADD = 2'd0;
    localparam logic [1:0] FN_AND = 2'd1;
    localparam logic [1:0] FN_XOR = 2'd2;
    localparam logic [1:0] FN_OR  = 2'd3;

    function automatic logic op_is_sub(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP);
    endfunction

    function automatic logic op_is_logic(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_XOR) || (op == OP_OR);
    endfunction

    function automatic logic [1:0] op_fn(input logic [2:0] op);
        case (op)
            OP_AND:  return FN_AND;
            OP_XOR:  return FN_XOR;
            OP_OR:   return FN_OR;
            default: return FN_ADD;
        endcase
    endfunction

    // Subtraction is a + ~b + 1, so a borrow-in of cf becomes carry-in of !cf.
    function automatic logic lo_carry_in(input logic [2:0] op, input logic cf);
        case (op)
            OP_ADC:        return cf;
            OP_SUB, OP_CP: return 1'b1;
            OP_SBC:        return ~cf;
            default:       return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] op_flags(input logic [2:0] op, input logic hc,
                                            input logic co, input logic zero);
        logic h;
        logic c;
        case (op)
            OP_ADD, OP_ADC:         begin h = hc;   c = co;   end
            OP_SUB, OP_SBC, OP_CP:  begin h = ~hc;  c = ~co;  end
            OP_AND:                 begin h = 1'b1; c = 1'b0; end
            default:                begin h = 1'b0; c = 1'b0; end
        endcase
        return {zero, op_is_sub(op), h, c};
    endfunction

    logic [2:0] state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic       cf_q, cf_d;
    logic       hc_q, hc_d;
    logic       ready_q, ready_d;
    logic       accept_s;

    logic [7:0] alu_op_q, alu_op_d;
    logic       alu_la_q, alu_la_d;
    logic       alu_lb_q, alu_lb_d;
    logic [1:0] alu_fn_q, alu_fn_d;
    logic       alu_neg_q, alu_neg_d;
    logic       alu_ci_q, alu_ci_d;
    logic       alu_lo_q, alu_lo_d;
    logic       alu_hi_q, alu_hi_d;
    logic       alu_res_oe_q, alu_res_oe_d;

    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_wr_q, rsp_wr_d;
    logic [7:0] rsp_result_q, rsp_result_d;
    logic [3:0] rsp_flags_q, rsp_flags_d;

    assign accept_s = req_valid && ready_q;

    // Sequencing, operand capture, half-carry and response capture.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cf_d    = cf_q;
        case (state_q)
            ST_IDLE: if (accept_s) state_d = ST_LDA; else state_d = ST_IDLE;
            ST_LDA:  state_d = ST_LO;
            ST_LO:   state_d = ST_HI;
            ST_HI:   state_d = ST_DONE;
            ST_DONE: if (accept_s) state_d = ST_LDA; else state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (accept_s) begin
            op_d = req_op;
            a_d  = req_a;
            b_d  = req_b;
            cf_d = req_cf;
        end else begin
            op_d = op_q;
        end
        if (state_q == ST_LO) begin
            hc_d = alu_carry;
        end else begin
            hc_d = hc_q;
        end
        ready_d     = (state_d == ST_IDLE) || (state_d == ST_DONE);
        rsp_valid_d = (state_q == ST_HI);
        if (state_q == ST_HI) begin
            rsp_result_d = alu_result;
            rsp_flags_d  = op_flags(op_q, hc_q, alu_carry, alu_zero);
            rsp_wr_d     = (op_q != OP_CP);
        end else begin
            rsp_result_d = rsp_result_q;
            rsp_flags_d  = rsp_flags_q;
            rsp_wr_d     = rsp_wr_q;
        end
    end

    // ALU control for the upcoming state, registered so the outputs are glitch-free.
    always_comb begin
        alu_op_d     = 8'd0;
        alu_la_d     = 1'b0;
        alu_lb_d     = 1'b0;
        alu_fn_d     = FN_ADD;
        alu_neg_d    = 1'b0;
        alu_ci_d     = 1'b0;
        alu_lo_d     = 1'b0;
        alu_hi_d     = 1'b0;
        alu_res_oe_d = 1'b0;
        case (state_d)
            ST_LDA: begin
                alu_op_d = a_d;
                alu_la_d = 1'b1;
            end
            ST_LO: begin
                alu_op_d  = b_d;
                alu_lb_d  = 1'b1;
                alu_lo_d  = 1'b1;
                alu_fn_d  = op_fn(op_d);
                alu_neg_d = op_is_sub(op_d);
                alu_ci_d  = lo_carry_in(op_d, cf_d);
            end
            ST_HI: begin
                alu_hi_d     = 1'b1;
                alu_res_oe_d = 1'b1;
                alu_ci_d     = op_is_logic(op_d) ? 1'b0 : hc_d;
            end
            default: begin
                alu_op_d = 8'd0;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_q         <= 3'd0;
            a_q          <= 8'd0;
            b_q          <= 8'd0;
            cf_q         <= 1'b0;
            hc_q         <= 1'b0;
            ready_q      <= 1'b1;
            alu_op_q     <= 8'd0;
            alu_la_q     <= 1'b0;
            alu_lb_q     <= 1'b0;
            alu_fn_q     <= 2'd0;
            alu_neg_q    <= 1'b0;
            alu_ci_q     <= 1'b0;
            alu_lo_q     <= 1'b0;
            alu_hi_q     <= 1'b0;
            alu_res_oe_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_wr_q     <= 1'b0;
            rsp_result_q <= 8'd0;
            rsp_flags_q  <= 4'd0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cf_q         <= cf_d;
            hc_q         <= hc_d;
            ready_q      <= ready_d;
            alu_op_q     <= alu_op_d;
            alu_la_q     <= alu_la_d;
            alu_lb_q     <= alu_lb_d;
            alu_fn_q     <= alu_fn_d;
            alu_neg_q    <= alu_neg_d;
            alu_ci_q     <= alu_ci_d;
            alu_lo_q     <= alu_lo_d;
            alu_hi_q     <= alu_hi_d;
            alu_res_oe_q <= alu_res_oe_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_wr_q     <= rsp_wr_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign req_ready  = ready_q;
    assign alu_op     = alu_op_q;
    assign alu_la     = alu_la_q;
    assign alu_lb     = alu_lb_q;
    assign alu_fn     = alu_fn_q;
    assign alu_neg    = alu_neg_q;
    assign alu_ci     = alu_ci_q;
    assign alu_lo     = alu_lo_q;
    assign alu_hi     = alu_hi_q;
    assign alu_res_oe = alu_res_oe_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_wr     = rsp_wr_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a behavioral nibble ALU closes the loop and a scoreboard
// queue of expected responses is checked whenever rsp_valid pulses.
module tb_alu_seq;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       req_cf;
    logic [7:0] alu_op;
    logic       alu_la;
    logic       alu_lb;
    logic [1:0] alu_fn;
    logic       alu_neg;
    logic       alu_ci;
    logic       alu_lo;
    logic       alu_hi;
    logic       alu_res_oe;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic       alu_zero;
    logic       rsp_valid;
    logic       rsp_wr;
    logic [7:0] rsp_result;
    logic [3:0] rsp_flags;

    typedef struct {
        logic [7:0] res;
        logic [3:0] flags;
        logic       wr;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    alu_seq dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_cf(req_cf),
        .alu_op(alu_op), .alu_la(alu_la), .alu_lb(alu_lb), .alu_fn(alu_fn),
        .alu_neg(alu_neg), .alu_ci(alu_ci), .alu_lo(alu_lo), .alu_hi(alu_hi),
        .alu_res_oe(alu_res_oe), .alu_result(alu_result), .alu_carry(alu_carry),
        .alu_zero(alu_zero), .rsp_valid(rsp_valid), .rsp_wr(rsp_wr),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioral 4-bit ALU: latches A, B and function on load strobes.
    logic [7:0] a_lat = 8'd0, b_lat = 8'd0;
    logic [1:0] fn_lat = 2'd0;
    logic       neg_lat = 1'b0;
    logic [3:0] lo_lat = 4'd0;
    logic [3:0] lo_b, lo_val, hi_b, hi_val;
    logic [4:0] lo_sum, hi_sum;

    always @(posedge clk) begin
        if (alu_la) a_lat <= alu_op;
        if (alu_lb) begin
            b_lat   <= alu_op;
            fn_lat  <= alu_fn;
            neg_lat <= alu_neg;
            lo_lat  <= lo_val;
        end
    end

    always_comb begin
        lo_b   = alu_neg ? ~alu_op[3:0] : alu_op[3:0];
        lo_sum = {1'b0, a_lat[3:0]} + {1'b0, lo_b} + {4'd0, alu_ci};
        case (alu_fn)
            2'd0:    lo_val = lo_sum[3:0];
            2'd1:    lo_val = a_lat[3:0] & alu_op[3:0];
            2'd2:    lo_val = a_lat[3:0] ^ alu_op[3:0];
            default: lo_val = a_lat[3:0] | alu_op[3:0];
        endcase
        hi_b   = neg_lat ? ~b_lat[7:4] : b_lat[7:4];
        hi_sum = {1'b0, a_lat[7:4]} + {1'b0, hi_b} + {4'd0, alu_ci};
        case (fn_lat)
            2'd0:    hi_val = hi_sum[3:0];
            2'd1:    hi_val = a_lat[7:4] & b_lat[7:4];
            2'd2:    hi_val = a_lat[7:4] ^ b_lat[7:4];
            default: hi_val = a_lat[7:4] | b_lat[7:4];
        endcase
        alu_result = {hi_val, lo_lat};
        alu_zero   = (alu_result == 8'd0);
        if (alu_hi)      alu_carry = (fn_lat == 2'd0) && hi_sum[4];
        else if (alu_lo) alu_carry = (alu_fn == 2'd0) && lo_sum[4];
        else             alu_carry = 1'b0;
    end

    // Scoreboard: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rsp_valid) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: rsp_valid with no outstanding op at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if ({rsp_result, rsp_flags, rsp_wr} !== {e.res, e.flags, e.wr} || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL rsp: got res=%h flags=%b wr=%b cyc=%0d, expected res=%h flags=%b wr=%b cyc=%0d",
                             rsp_result, rsp_flags, rsp_wr, cyc, e.res, e.flags, e.wr, e.cyc);
                end
            end
        end
    end

    // Independent reference: whole-byte arithmetic with borrow semantics for subtracts.
    function automatic exp_t ref_op(input logic [2:0] op, input logic [7:0] a,
                                    input logic [7:0] b, input logic cf);
        exp_t       e;
        logic [8:0] s;
        logic [4:0] h;
        logic       cin;
        logic       n_f, h_f, c_f;
        n_f = 1'b0; h_f = 1'b0; c_f = 1'b0;
        case (op)
            3'd0, 3'd1: begin
                cin = (op == 3'd1) ? cf : 1'b0;
                s = {1'b0, a} + {1'b0, b} + {8'd0, cin};
                h = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, cin};
                e.res = s[7:0]; h_f = h[4]; c_f = s[8];
            end
            3'd2, 3'd3, 3'd7: begin
                cin = (op == 3'd3) ? cf : 1'b0;
                e.res = a - b - {7'd0, cin};
                h_f = ({1'b0, a[3:0]} < ({1'b0, b[3:0]} + {4'd0, cin}));
                c_f = ({1'b0, a} < ({1'b0, b} + {8'd0, cin}));
                n_f = 1'b1;
            end
            3'd4:    begin e.res = a & b; h_f = 1'b1; end
            3'd5:    e.res = a ^ b;
            default: e.res = a | b;
        endcase
        e.flags = {(e.res == 8'd0), n_f, h_f, c_f};
        e.wr    = (op != 3'd7);
        e.cyc   = 0;
        return e;
    endfunction

    // Drives one request, waits for acceptance, pushes its expectation; returns 1 ns after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic cf, input logic keep, input logic [7:0] eres,
                         input logic [3:0] eflags, input logic ewr);
        exp_t e;
        logic ok;
        @(negedge clk);
        req_op = op; req_a = a; req_b = b; req_cf = cf; req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL accept_timeout: req_ready=%b, expected 1 within 20 cycles", req_ready);
        end
        e.res = eres; e.flags = eflags; e.wr = ewr; e.cyc = cyc + 4;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        req_a = ~a; req_b = ~b; req_op = ~op; req_cf = ~cf;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 30 && sb_q.size() != 0; i++) @(negedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL rsp_timeout: %0d responses outstanding, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic check_quiet(input string name);
        logic [30:0] outs;
        outs = {alu_op, alu_la, alu_lb, alu_fn, alu_neg, alu_ci, alu_lo, alu_hi, alu_res_oe,
                rsp_valid, rsp_wr, rsp_result, rsp_flags};
        n_tests++;
        if (outs !== 31'd0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: outputs=%h req_ready=%b, expected outputs=0 req_ready=1", name, outs, req_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_a = 8'd0; req_b = 8'd0; req_cf = 1'b0;
        #12;
        check_quiet("reset_state");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_add();
        issue(3'd0, 8'h3A, 8'hC6, 1'b0, 1'b0, 8'h00, 4'b1011, 1'b1);
        n_tests++;
        if (alu_la !== 1'b1 || alu_op !== 8'h3A || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL add_lda: la=%b op=%h ready=%b, expected la=1 op=3a ready=0", alu_la, alu_op, req_ready);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_tests++;
        if ({alu_hi, alu_res_oe, alu_ci, alu_lo, alu_lb} !== 5'b11100) begin
            n_fail++;
            $display("FAIL add_hi: hi/oe/ci/lo/lb=%b, expected 11100", {alu_hi, alu_res_oe, alu_ci, alu_lo, alu_lb});
        end
        wait_done();
    endtask

    task automatic test_sub();
        issue(3'd2, 8'h3E, 8'h0F, 1'b0, 1'b0, 8'h2F, 4'b0110, 1'b1);
        @(posedge clk); #1;
        n_tests++;
        if ({alu_neg, alu_ci, alu_lo, alu_lb, alu_fn} !== 6'b111100 || alu_op !== 8'h0F) begin
            n_fail++;
            $display("FAIL sub_lo: neg/ci/lo/lb/fn=%b op=%h, expected 111100 op=0f",
                     {alu_neg, alu_ci, alu_lo, alu_lb, alu_fn}, alu_op);
        end
        wait_done();
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b0 || rsp_result !== 8'h2F || rsp_flags !== 4'b0110) begin
            n_fail++;
            $display("FAIL sub_hold: valid=%b res=%h flags=%b, expected valid=0 res=2f flags=0110",
                     rsp_valid, rsp_result, rsp_flags);
        end
    endtask

    task automatic test_carry_ops();
        issue(3'd1, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 4'b1011, 1'b1);
        wait_done();
        issue(3'd3, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 4'b0111, 1'b1);
        wait_done();
    endtask

    task automatic test_cp_logic();
        issue(3'd7, 8'h10, 8'h20, 1'b0, 1'b0, 8'hF0, 4'b0101, 1'b0);
        wait_done();
        issue(3'd4, 8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00, 4'b1010, 1'b1);
        wait_done();
        issue(3'd5, 8'h55, 8'h55, 1'b1, 1'b0, 8'h00, 4'b1000, 1'b1);
        wait_done();
    endtask

    task automatic test_random();
        exp_t e;
        logic [2:0] op;
        logic [7:0] a, b;
        logic cf;
        for (int k = 0; k < 16; k++) begin
            op = 3'($urandom_range(7, 0));
            a  = 8'($urandom_range(255, 0));
            b  = 8'($urandom_range(255, 0));
            cf = 1'($urandom_range(1, 0));
            e  = ref_op(op, a, b, cf);
            issue(op, a, b, cf, 1'b0, e.res, e.flags, e.wr);
            wait_done();
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        issue(3'd0, 8'h12, 8'h34, 1'b0, 1'b1, 8'h46, 4'b0000, 1'b1);
        t1 = cyc;
        issue(3'd6, 8'hA0, 8'h05, 1'b0, 1'b0, 8'hA5, 4'b0000, 1'b1);
        t2 = cyc;
        n_tests++;
        if (t2 - t1 != 4) begin
            n_fail++;
            $display("FAIL b2b_spacing: accepts %0d cycles apart, expected 4", t2 - t1);
        end
        wait_done();
    endtask

    task automatic test_reset_mid_op();
        issue(3'd0, 8'h3A, 8'hC6, 1'b0, 1'b0, 8'h00, 4'b1011, 1'b1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check_quiet("reset_mid_lo");
        void'(sb_q.pop_back());
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        issue(3'd0, 8'h08, 8'h08, 1'b0, 1'b0, 8'h10, 4'b0010, 1'b1);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_carry_ops();
        test_cp_logic();
        test_random();
        test_back_to_back();
        test_reset_mid_op();
        repeat (6) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Nibble-serial ALU sequencer for the 8-bit arithmetic/logic group (ADD, ADC, SUB, SBC, AND, XOR, OR, CP). It sits directly upstream of the 4-bit ALU datapath and is driven by the decoder. It accepts one 8-bit operation per request and drives the ALU control lines over three cycles: load A, low nibble, high nibble. It keeps the inter-nibble half-carry and returns the 8-bit result with Z/N/H/C flags.

## Interface
Parameters: none.

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  operation request
- req_ready  out  1  sequencer can accept; high in IDLE and DONE
- req_op  in  3  0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP
- req_a  in  8  accumulator operand
- req_b  in  8  second operand
- req_cf  in  1  current C flag, used by ADC/SBC
- alu_op  out  8  operand bus into ALU
- alu_la  out  1  load ALU A latch from alu_op
- alu_lb  out  1  load ALU B latch from alu_op
- alu_fn  out  2  0 add, 1 and, 2 xor, 3 or
- alu_neg  out  1  invert B operand (subtract)
- alu_ci  out  1  nibble carry-in
- alu_lo  out  1  operate on low nibble
- alu_hi  out  1  operate on high nibble
- alu_res_oe  out  1  ALU drives 8-bit result
- alu_result  in  8  ALU result; valid in HI
- alu_carry  in  1  nibble carry-out; valid in LO and HI
- alu_zero  in  1  result == 0; valid in HI
- rsp_valid  out  1  one-cycle pulse: response valid
- rsp_wr  out  1  write rsp_result to A; 0 for CP
- rsp_result  out  8  operation result
- rsp_flags  out  4  {Z, N, H, C}

## Operation
- States: IDLE, LDA, LO, HI, DONE.
  - IDLE/DONE + accept → LDA.
  - DONE without accept → IDLE.
  - LDA → LO → HI → DONE unconditionally.
- Accept = req_valid && req_ready. On accept, register op, a, b, cf. Later req_* changes have no effect.
- LDA: alu_op = a, alu_la = 1.
- LO: alu_op = b, alu_lb = 1, alu_lo = 1, alu_fn/alu_neg per op.
- Carry-in in LO:
  - ADD = 0; ADC = cf; SUB/CP = 1; SBC = !cf.
  - Logic ops = 0.
- End of LO: latch hc <= alu_carry.
- HI: alu_hi = 1, alu_ci = hc (logic ops 0), alu_res_oe = 1.
- End of HI: capture alu_result, alu_carry, alu_zero.
- alu_neg = 1 for SUB, SBC, CP; else 0.
- alu_fn = add for ADD/ADC/SUB/SBC/CP; and/xor/or for logic ops.
- Flags (hc = low-nibble carry, co = high-nibble carry):
  - Z = alu_zero.
  - N = 1 for SUB/SBC/CP, else 0.
  - H: ADD/ADC → hc; SUB/SBC/CP → !hc; AND → 1; XOR/OR → 0.
  - C: ADD/ADC → co; SUB/SBC/CP → !co; logic ops → 0.
- rsp_wr = 0 for CP, 1 otherwise.
- All alu_* outputs are 0 in IDLE and DONE, and for any field not listed for a state.

## Timing
- Accept at edge T → LDA in cycle T+1, LO T+2, HI T+3, DONE T+4.
- rsp_valid high exactly in cycle T+4, with rsp_result/rsp_flags/rsp_wr stable.
- rsp_* hold their value until the next HI capture.
- Throughput: one op per 4 cycles when req_valid is held high (accept in DONE).
- No response backpressure: the consumer must take rsp in the rsp_valid cycle.
- req_ready is a function of state only; no combinational path from req_valid.
- Reset (any time, including mid-sequence) has immediate effect:
  - state = IDLE; hc = 0.
  - rsp_valid = 0, rsp_result = 0, rsp_flags = 0, rsp_wr = 0.
  - All alu_* = 0; req_ready = 1 after reset.
- An aborted op produces no rsp_valid.

## Test plan
The bench pairs alu_seq with a behavioral nibble ALU model.
- ADD a=0x3A b=0xC6 → rsp_result 0x00, flags Z1 N0 H1 C1, rsp_wr 1, rsp_valid 4 cycles after accept.
- SUB a=0x3E b=0x0F → 0x2F, flags Z0 N1 H1 C0; alu_neg=1 and alu_ci=1 in LO.
- ADC a=0xFF b=0x00 cf=1 → 0x00, Z1 N0 H1 C1. SBC a=0x00 b=0x00 cf=1 → 0xFF, Z0 N1 H1 C1.
- CP a=0x10 b=0x20 → rsp_wr 0, flags Z0 N1 H0 C1. AND 0x0F&0xF0 → 0x00, Z1 N0 H1 C0. XOR 0x55^0x55 → 0x00, Z1 H0 C0.
- req_valid held high with ops ADD then OR, no idle gap between them → second accept occurs in DONE. rsp_valid pulses at T+4 and T+8 with correct values.
- Reset asserted during LO of an ADD → all outputs 0 asynchronously, no rsp_valid. Next request after reset release completes normally with hc starting from 0.
